// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD display scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    UNITS    = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } slot_t;

  localparam logic [6:0] SEG_0   = 7'b0111111;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_3   = 7'b1001111;
  localparam logic [6:0] SEG_4   = 7'b1100110;
  localparam logic [6:0] SEG_5   = 7'b1101101;
  localparam logic [6:0] SEG_6   = 7'b1111101;
  localparam logic [6:0] SEG_7   = 7'b0000111;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1101111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/bcd_combinational.sv
// Binary 0..255 to three BCD digits.
// Hundreds fits in two bits since the input tops out at 255.
module bcd_combinational (
  input  logic [7:0] bin,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [6:0] rem;

  always_comb begin
    hundreds = 2'd0;
    if (bin >= 8'd200)
      hundreds = 2'd2;
    else if (bin >= 8'd100)
      hundreds = 2'd1;
    rem   = 7'(bin - 8'(hundreds) * 8'd100);
    tens  = 4'(rem / 7'd10);
    units = 4'(rem % 7'd10);
  end

endmodule

// File: rtl/seg7_decode.sv
// BCD digit to active-high {g..a} segment pattern.
// Non-decimal codes render as blank.
module seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed 7-seg scanner with a one-entry
// pending slot, leading-zero blanking and anti-ghost gaps.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int unsigned DWELL          = 4000,
  parameter int unsigned GAP            = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [6:0] seg,
  output logic [2:0] digit_en,
  output logic       frame_done
);

  localparam logic [6:0] POL      = {7{SEG_ACTIVE_LOW}};
  localparam logic [6:0] SEG_IDLE = SEG_OFF ^ POL;

  slot_t       slot, slot_nxt;
  logic [15:0] slot_cnt;
  logic [7:0]  disp_val;
  logic [7:0]  pend_val;
  logic        pend_full, pend_full_nxt;
  logic        last, boundary, xfer;

  logic [1:0]  hundreds;
  logic [3:0]  tens, units;
  logic [3:0]  cur_bcd;
  logic [6:0]  cur_seg;
  logic [2:0]  onehot;
  logic        lit;

  assign last     = (slot_cnt == 16'(DWELL - 1));
  assign boundary = last && (slot == HUNDREDS);
  assign xfer     = data_valid && data_ready;

  always_comb begin
    slot_nxt = slot;
    if (last) begin
      unique case (slot)
        UNITS:   slot_nxt = TENS;
        TENS:    slot_nxt = HUNDREDS;
        default: slot_nxt = UNITS;
      endcase
    end
  end

  always_comb begin
    pend_full_nxt = pend_full;
    if (boundary)
      pend_full_nxt = 1'b0;
    if (xfer)
      pend_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot      <= UNITS;
      slot_cnt  <= '0;
      disp_val  <= '0;
      pend_val  <= '0;
      pend_full <= 1'b0;
    end else begin
      slot      <= slot_nxt;
      slot_cnt  <= last ? '0 : slot_cnt + 16'd1;
      pend_full <= pend_full_nxt;
      if (boundary && pend_full)
        disp_val <= pend_val;
      if (xfer)
        pend_val <= data_in;
    end
  end

  bcd_combinational u_bcd (
    .bin      (disp_val),
    .hundreds (hundreds),
    .tens     (tens),
    .units    (units)
  );

  // Tens stays lit under a nonzero hundreds digit (e.g. 105).
  always_comb begin
    cur_bcd = '0;
    onehot  = '0;
    lit     = 1'b0;
    unique case (slot)
      UNITS: begin
        cur_bcd = units;
        onehot  = 3'b001;
        lit     = 1'b1;
      end
      TENS: begin
        cur_bcd = tens;
        onehot  = 3'b010;
        lit     = (hundreds != 2'd0) || (tens != 4'd0);
      end
      HUNDREDS: begin
        cur_bcd = {2'b00, hundreds};
        onehot  = 3'b100;
        lit     = (hundreds != 2'd0);
      end
      default: ;
    endcase
    if (slot_cnt < 16'(GAP))
      lit = 1'b0;
  end

  seg7_decode u_seg (
    .bcd (cur_bcd),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg        <= SEG_IDLE;
      digit_en   <= '0;
      frame_done <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      seg        <= (lit ? cur_seg : SEG_OFF) ^ POL;
      digit_en   <= lit ? onehot : 3'b000;
      frame_done <= boundary;
      data_ready <= !pend_full_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner against a
// frame-position reference model with a queue-based pending slot.
module tb_bcd_display_scanner;

  localparam int D = 8;
  localparam int G = 2;
  localparam int FRAME = 3 * D;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_ready;
  logic [6:0] seg;
  logic [2:0] digit_en;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .DWELL          (D),
    .GAP            (G),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference: n counts live edges since reset, so n mod FRAME
  // is the frame position the outputs of this edge describe.
  int         n = 0;
  int         m_disp = 0;
  int         m_pend[$];
  logic [2:0] e_en = 3'b000;
  logic [6:0] e_seg = 7'h7f;
  logic       e_fd = 1'b0;
  logic       e_rdy = 1'b0;

  always @(posedge clk) begin : model
    int p, sl, cnt, h, t, u, dg;
    bit lit;
    if (!reset_n) begin
      n = 0;
      m_disp = 0;
      m_pend.delete();
      e_en = 3'b000;
      e_seg = 7'h7f;
      e_fd = 1'b0;
      e_rdy = 1'b0;
    end else begin
      p = n % FRAME;
      sl = p / D;
      cnt = p % D;
      h = m_disp / 100;
      t = (m_disp / 10) % 10;
      u = m_disp % 10;
      case (sl)
        0: begin dg = u; lit = 1'b1; end
        1: begin dg = t; lit = (h != 0) || (t != 0); end
        default: begin dg = h; lit = (h != 0); end
      endcase
      lit = lit && (cnt >= G);
      e_en = lit ? 3'(1 << sl) : 3'b000;
      e_seg = lit ? ~glyph(dg) : 7'h7f;
      e_fd = (p == FRAME - 1);
      if (e_fd && m_pend.size() > 0)
        m_disp = m_pend.pop_front();
      if (data_valid && e_rdy)
        m_pend.push_back(int'(data_in));
      e_rdy = (m_pend.size() == 0);
      n++;
    end
  end

  always @(negedge clk) begin
    check("digit_en", 32'(digit_en), 32'(e_en));
    check("seg", 32'(seg), 32'(e_seg));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("data_ready", 32'(data_ready), 32'(e_rdy));
  end

  task automatic push(input logic [7:0] v);
    bit took;
    took = 1'b0;
    data_valid = 1'b1;
    data_in = v;
    for (int i = 0; i < 200 && !took; i++) begin
      took = data_ready;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check("push_accept", 32'(took), 32'd1);
  endtask

  task automatic wait_slot(input int want);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      if ((n % FRAME) / D == want)
        hit = 1'b1;
      else
        @(negedge clk);
    end
    check("slot_wait", 32'(hit), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_en", 32'(digit_en), 32'd0);
    check("rst_seg", 32'(seg), 32'h7f);
    check("rst_rdy", 32'(data_ready), 32'd0);
    reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    push(8'd255);
    repeat (2 * FRAME) @(negedge clk);
    push(8'd7);
    repeat (2 * FRAME) @(negedge clk);
    push(8'd105);
    repeat (2 * FRAME) @(negedge clk);

    push(8'd42);
    push(8'd200);
    repeat (3 * FRAME) @(negedge clk);

    wait_slot(0);
    push(8'd99);
    wait_slot(1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_en", 32'(digit_en), 32'd0);
    check("mid_rst_seg", 32'(seg), 32'h7f);
    reset_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: data_in = 8'($urandom_range(0, 9));
        1: data_in = 8'($urandom_range(10, 99));
        default: data_in = 8'($urandom);
      endcase
      reset_n = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    reset_n = 1'b1;
    repeat (FRAME) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
